// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder
// Accepts one word load/store, waits LATENCY cycles, then holds the response until consumed.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_C = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_TOP = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          write_q, write_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;
   logic          resp_err_q, resp_err_d;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          mem_we;
   logic          acc_err;
   logic [AW-1:0] idx;

   assign acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_C);
   assign idx     = addr_q[AW+1:2];

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_BUSY;
               cnt_d   = CNT_TOP;
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         S_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // The access happens on the same edge that enters RESP.
               state_d      = S_RESP;
               resp_err_d   = acc_err;
               resp_rdata_d = (!acc_err && !write_q) ? mem_q[idx] : 32'd0;
               mem_we       = write_q && !acc_err;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               resp_rdata_d = 32'd0;
               resp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Storage has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// Instance a uses LATENCY=4, instance b uses LATENCY=1.
module tb_data_mem_responder;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic        clk;
   logic        reset;

   logic        a_req_valid, a_req_ready, a_req_write;
   logic [31:0] a_req_addr, a_req_wdata;
   logic        a_resp_valid, a_resp_ready, a_resp_err;
   logic [31:0] a_resp_rdata;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [31:0] b_req_addr, b_req_wdata;
   logic        b_resp_valid, b_resp_ready, b_resp_err;
   logic [31:0] b_resp_rdata;

   int n_total;
   int n_pass;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) u_dut_a (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (a_req_valid),
      .req_ready  (a_req_ready),
      .req_write  (a_req_write),
      .req_addr   (a_req_addr),
      .req_wdata  (a_req_wdata),
      .resp_valid (a_resp_valid),
      .resp_ready (a_resp_ready),
      .resp_rdata (a_resp_rdata),
      .resp_err   (a_resp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_B)) u_dut_b (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (b_req_valid),
      .req_ready  (b_req_ready),
      .req_write  (b_req_write),
      .req_addr   (b_req_addr),
      .req_wdata  (b_req_wdata),
      .resp_valid (b_resp_valid),
      .resp_ready (b_resp_ready),
      .resp_rdata (b_resp_rdata),
      .resp_err   (b_resp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Waits (from a negedge) until a_resp_valid is seen; lat counts rising edges waited.
   task automatic wait_resp_a(output int lat);
      lat = 0;
      while (!a_resp_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!a_resp_valid) check("a_resp_timeout", 32'd0, 32'd1);
   endtask

   // Full request on instance a with resp_ready held high; called at a negedge.
   task automatic do_req_a(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
      int lat;
      check({tag, "_req_ready"}, {31'd0, a_req_ready}, 32'd1);
      a_resp_ready = 1'b1;
      a_req_valid  = 1'b1;
      a_req_write  = wr;
      a_req_addr   = addr;
      a_req_wdata  = wdata;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      a_req_write = 1'b0;
      wait_resp_a(lat);
      check({tag, "_latency"}, 32'(lat), 32'(LAT_A));
      check({tag, "_rdata"}, a_resp_rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, a_resp_err}, {31'd0, exp_err});
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ready_after"}, {31'd0, a_req_ready}, 32'd1);
      check({tag, "_cleared"}, {a_resp_rdata[30:0], a_resp_err}, 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      int last_pulse;
      n_total = 0;
      n_pass  = 0;

      reset        = 1'b0;
      a_req_valid  = 1'b0;
      a_req_write  = 1'b0;
      a_req_addr   = 32'd0;
      a_req_wdata  = 32'd0;
      a_resp_ready = 1'b1;
      b_req_valid  = 1'b0;
      b_req_write  = 1'b0;
      b_req_addr   = 32'd0;
      b_req_wdata  = 32'd0;
      b_resp_ready = 1'b1;

      #1;
      check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("rst_resp_rdata", a_resp_rdata, 32'd0);
      check("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Basic store then load
      do_req_a("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      do_req_a("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Backpressure with a competing request presented during RESP
      a_resp_ready = 1'b0;
      a_req_valid  = 1'b1;
      a_req_write  = 1'b0;
      a_req_addr   = 32'h10;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      wait_resp_a(lat);
      check("bp_latency", 32'(lat), 32'(LAT_A));
      for (int i = 0; i < 3; i++) begin
         a_req_valid = 1'b1;
         a_req_write = 1'b1;
         a_req_addr  = 32'h10;
         a_req_wdata = 32'h12345678;
         @(posedge clk);
         @(negedge clk);
         check("bp_valid_held", {31'd0, a_resp_valid}, 32'd1);
         check("bp_rdata_held", a_resp_rdata, 32'hDEADBEEF);
         check("bp_req_ready_low", {31'd0, a_req_ready}, 32'd0);
      end
      a_resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_ready_after", {31'd0, a_req_ready}, 32'd1);
      check("bp_valid_after", {31'd0, a_resp_valid}, 32'd0);
      a_req_valid = 1'b0;
      a_req_write = 1'b0;
      do_req_a("bp_reload", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Error cases
      do_req_a("st0", 1'b1, 32'h0, 32'hA5A5A5A5, 32'd0, 1'b0);
      do_req_a("ld_mis", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
      do_req_a("st_oor", 1'b1, 32'h1000, 32'hCAFEF00D, 32'd0, 1'b1);
      do_req_a("ld0", 1'b0, 32'h0, 32'd0, 32'hA5A5A5A5, 1'b0);

      // Reset during BUSY discards the pending store
      do_req_a("st20_old", 1'b1, 32'h20, 32'h11111111, 32'd0, 1'b0);
      a_req_valid = 1'b1;
      a_req_write = 1'b1;
      a_req_addr  = 32'h20;
      a_req_wdata = 32'h55AA55AA;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      a_req_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_busy", {31'd0, a_req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("mid_rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("mid_rst_rdata", a_resp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      do_req_a("ld20", 1'b0, 32'h20, 32'd0, 32'h11111111, 1'b0);

      // LATENCY=1 instance: store, then back-to-back loads with req_valid held
      b_req_valid = 1'b1;
      b_req_write = 1'b1;
      b_req_addr  = 32'h8;
      b_req_wdata = 32'h0BADCAFE;
      lat = 0;
      while (!b_resp_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("b_store_latency", 32'(lat), 32'(LAT_B + 1));
      b_req_write = 1'b0;
      pulses     = 0;
      last_pulse = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (b_resp_valid) begin
            pulses++;
            check("b_gap", 32'(i - last_pulse), 32'(LAT_B + 2));
            check("b_rdata", b_resp_rdata, 32'h0BADCAFE);
            last_pulse = i;
         end
      end
      check("b_pulses", 32'(pulses), 32'd4);
      b_req_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
